// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared Wishbone B3 definitions for the memory-controller slice.
//   - BTE (burst type extension) and CTI (cycle type) encodings
//   - arbiter FSM state encoding, also visible on the arbiter debug port
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_BEAT4  = 2'b01;
    localparam logic [1:0] BTE_BEAT8  = 2'b10;
    localparam logic [1:0] BTE_BEAT16 = 2'b11;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wb_rr_pick.sv
// -----------------------------------------------------------------------------
// wb_rr_pick
// Combinational rotating-priority picker.
//   req  [NM]  request vector
//   last [NM]  one-hot of the previous winner
//   gnt  [NM]  one-hot of the first requester after 'last' (modulo NM),
//              all zero when nothing requests
// -----------------------------------------------------------------------------
module wb_rr_pick #(
    parameter int NM = 2
) (
    input  logic [NM-1:0] req,
    input  logic [NM-1:0] last,
    output logic [NM-1:0] gnt
);

    localparam int IW = (NM > 1) ? $clog2(NM) : 1;

    int            last_idx;
    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        gnt      = '0;
        found    = 1'b0;
        idx      = '0;
        last_idx = NM - 1;
        for (int i = 0; i < NM; i++) begin
            if (last[i]) last_idx = i;
        end
        // Scan starting one past the previous winner; the previous winner
        // itself is visited last, so it only wins again when alone.
        for (int k = 1; k <= NM; k++) begin
            idx = IW'((last_idx + k) % NM);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_burst_arbiter.sv
// -----------------------------------------------------------------------------
// wb_burst_arbiter
// Round-robin arbiter sharing one Wishbone B3 slave port among NM masters.
// A grant is held for the whole cycle (cyc high), so classic, incrementing and
// eob bursts, and read-modify-write sequences, are never split.
//
// Handshake: a beat transfers on a rising edge where s_cyc_o & s_stb_o & s_ack_i
// are all high; stb plays the role of valid, ack the role of ready, and a master
// keeps its fields stable while stb is high and ack is low.
//
// Ports
//   clk, reset                      clock, async active-high reset
//   m_adr_i/bte/cti/dat/sel/we      packed master fields, master k in slice k
//   m_cyc_i, m_stb_i                per-master cycle / strobe
//   m_dat_o                         slave read data broadcast to every master
//   m_ack_o                         slave ack routed to the granted master only
//   m_err_o                         timeout error pulse (zero unless enabled)
//   s_*_o                           fields of the granted master toward slave
//   s_dat_i, s_ack_i                slave read data and ack
//   gnt_o                           registered one-hot grant
//   dbg_state                       arbiter FSM state
//
// Optional feature: define WB_ARB_TIMEOUT_EN to add a stall counter that, after
// TIMEOUT strobe cycles without ack, pulses m_err_o of the owner for one cycle
// and masks s_stb_o in that cycle. Without it a hung slave keeps the grant.
// -----------------------------------------------------------------------------
module wb_burst_arbiter
    import wb_pkg::*;
#(
    parameter int NM      = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NM*AW-1:0]     m_adr_i,
    input  logic [NM*2-1:0]      m_bte_i,
    input  logic [NM*3-1:0]      m_cti_i,
    input  logic [NM*DW-1:0]     m_dat_i,
    input  logic [NM*DW/8-1:0]   m_sel_i,
    input  logic [NM-1:0]        m_we_i,
    input  logic [NM-1:0]        m_cyc_i,
    input  logic [NM-1:0]        m_stb_i,
    output logic [DW-1:0]        m_dat_o,
    output logic [NM-1:0]        m_ack_o,
    output logic [NM-1:0]        m_err_o,
    output logic [AW-1:0]        s_adr_o,
    output logic [1:0]           s_bte_o,
    output logic [2:0]           s_cti_o,
    output logic [DW-1:0]        s_dat_o,
    output logic [DW/8-1:0]      s_sel_o,
    output logic                 s_we_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    input  logic [DW-1:0]        s_dat_i,
    input  logic                 s_ack_i,
    output logic [NM-1:0]        gnt_o,
    output arb_state_e           dbg_state
);

    localparam int SW = DW / 8;
    // Reset pointer at the top master so master 0 is the first winner.
    localparam logic [NM-1:0] LAST_RST = {1'b1, {(NM-1){1'b0}}};

    arb_state_e    state;
    logic [NM-1:0] last_gnt;
    logic [NM-1:0] pick;
    logic          own_cyc;
    logic          raw_stb;

    assign dbg_state = state;

    wb_rr_pick #(.NM(NM)) u_pick (
        .req  (m_cyc_i),
        .last (last_gnt),
        .gnt  (pick)
    );

    assign own_cyc = |(gnt_o & m_cyc_i);
    assign raw_stb = |(gnt_o & m_stb_i);

    // Grant is cleared on the edge that sees the owner's cyc low, so a new
    // owner is always picked from IDLE: a one-cycle bubble between owners.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB_IDLE;
            gnt_o    <= '0;
            last_gnt <= LAST_RST;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|m_cyc_i) begin
                        gnt_o    <= pick;
                        last_gnt <= pick;
                        state    <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (!own_cyc) begin
                        gnt_o <= '0;
                        state <= ARB_IDLE;
                    end
                end
                default: begin
                    gnt_o <= '0;
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    // One-hot grant, so OR-ing the gated slices is a clean mux; with no grant
    // every field is zero and nothing from a non-owner reaches the slave.
    always_comb begin
        s_adr_o = '0;
        s_bte_o = '0;
        s_cti_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        for (int k = 0; k < NM; k++) begin
            if (gnt_o[k]) begin
                s_adr_o = s_adr_o | m_adr_i[k*AW +: AW];
                s_bte_o = s_bte_o | m_bte_i[k*2 +: 2];
                s_cti_o = s_cti_o | m_cti_i[k*3 +: 3];
                s_dat_o = s_dat_o | m_dat_i[k*DW +: DW];
                s_sel_o = s_sel_o | m_sel_i[k*SW +: SW];
                s_we_o  = s_we_o  | m_we_i[k];
            end
        end
    end

    assign s_cyc_o = own_cyc;
    assign m_ack_o = gnt_o & {NM{s_ack_i}};
    assign m_dat_o = s_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] to_cnt;
    logic          to_hit;

    assign to_hit = (to_cnt == CW'(TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state != ARB_BUSY || s_ack_i || to_hit) begin
            to_cnt <= '0;
        end else if (raw_stb) begin
            to_cnt <= to_cnt + CW'(1);
        end
    end

    // The stalled beat is withdrawn from the slave in the error cycle.
    assign s_stb_o = raw_stb & ~to_hit;
    assign m_err_o = gnt_o & {NM{to_hit}};
`else
    assign s_stb_o = raw_stb;
    assign m_err_o = '0;
`endif

endmodule

// File: tb/tb_wb_burst_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_burst_arbiter
// Directed bench for wb_burst_arbiter with three masters and TIMEOUT=8.
// Inputs are driven 1 time unit after the rising edge, outputs sampled there.
// -----------------------------------------------------------------------------
module tb_wb_burst_arbiter;
    import wb_pkg::*;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NM*AW-1:0]  m_adr;
    logic [NM*2-1:0]   m_bte;
    logic [NM*3-1:0]   m_cti;
    logic [NM*DW-1:0]  m_dat;
    logic [NM*SW-1:0]  m_sel;
    logic [NM-1:0]     m_we;
    logic [NM-1:0]     m_cyc;
    logic [NM-1:0]     m_stb;
    logic [DW-1:0]     m_dat_o;
    logic [NM-1:0]     m_ack_o;
    logic [NM-1:0]     m_err_o;
    logic [AW-1:0]     s_adr_o;
    logic [1:0]        s_bte_o;
    logic [2:0]        s_cti_o;
    logic [DW-1:0]     s_dat_o;
    logic [SW-1:0]     s_sel_o;
    logic              s_we_o;
    logic              s_cyc_o;
    logic              s_stb_o;
    logic [DW-1:0]     s_dat_i;
    logic              s_ack_i;
    logic [NM-1:0]     gnt_o;
    arb_state_e        dbg_state;

    int checks = 0;
    int errors = 0;

    wb_burst_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .m_adr_i   (m_adr),
        .m_bte_i   (m_bte),
        .m_cti_i   (m_cti),
        .m_dat_i   (m_dat),
        .m_sel_i   (m_sel),
        .m_we_i    (m_we),
        .m_cyc_i   (m_cyc),
        .m_stb_i   (m_stb),
        .m_dat_o   (m_dat_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .s_adr_o   (s_adr_o),
        .s_bte_o   (s_bte_o),
        .s_cti_o   (s_cti_o),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel_o),
        .s_we_o    (s_we_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .gnt_o     (gnt_o),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_adr   = '0;
        m_bte   = '0;
        m_cti   = '0;
        m_dat   = '0;
        m_sel   = '0;
        m_we    = '0;
        m_cyc   = '0;
        m_stb   = '0;
        s_dat_i = '0;
        s_ack_i = 1'b0;
    endtask

    // Leaves reset released 1 unit after an edge, all inputs idle.
    task automatic apply_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // ---------------- driver ----------------
    task automatic drive_master(input int k, input logic cyc, input logic stb,
                                input logic we, input logic [AW-1:0] adr,
                                input logic [DW-1:0] dat, input logic [2:0] cti,
                                input logic [1:0] bte);
        m_cyc[k]             = cyc;
        m_stb[k]             = stb;
        m_we[k]              = we;
        m_adr[k*AW +: AW]    = adr;
        m_dat[k*DW +: DW]    = dat;
        m_cti[k*3 +: 3]      = cti;
        m_bte[k*2 +: 2]      = bte;
        m_sel[k*SW +: SW]    = '1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        if (gnt_o !== 3'b000) begin
            $display("FAIL reset_gnt: got %b want 000", gnt_o); errors++;
        end
        checks++;
        if ({s_cyc_o, s_stb_o} !== 2'b00) begin
            $display("FAIL reset_cyc_stb: got %b want 00", {s_cyc_o, s_stb_o}); errors++;
        end
        checks++;
        if ({m_ack_o, m_err_o} !== 6'b0) begin
            $display("FAIL reset_ack_err: got %b want 000000", {m_ack_o, m_err_o}); errors++;
        end
        checks++;
        if (dbg_state !== ARB_IDLE) begin
            $display("FAIL reset_state: got %0d want IDLE", dbg_state); errors++;
        end
        checks++;
    endtask

    task automatic test_first_grant();
        apply_reset();
        // Both requests appear in the cycle reset is released.
        drive_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, CTI_CLASSIC, BTE_LINEAR);
        drive_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0, CTI_CLASSIC, BTE_LINEAR);
        tick();
        if (gnt_o !== 3'b001) begin
            $display("FAIL t1_first_gnt: got %b want 001", gnt_o); errors++;
        end
        checks++;
        if (s_cyc_o !== 1'b1 || s_adr_o !== 32'h0000_0010) begin
            $display("FAIL t1_slave_fields: got cyc=%b adr=%h want cyc=1 adr=00000010", s_cyc_o, s_adr_o); errors++;
        end
        checks++;
        drive_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC, BTE_LINEAR);
        #1;
        if (s_cyc_o !== 1'b0) begin
            $display("FAIL t1_cyc_drop: got %b want 0", s_cyc_o); errors++;
        end
        checks++;
        tick();
        if (gnt_o !== 3'b000 || dbg_state !== ARB_IDLE) begin
            $display("FAIL t1_bubble: got gnt=%b state=%0d want gnt=000 state=IDLE", gnt_o, dbg_state); errors++;
        end
        checks++;
        tick();
        if (gnt_o !== 3'b010) begin
            $display("FAIL t1_second_gnt: got %b want 010", gnt_o); errors++;
        end
        checks++;
    endtask

    task automatic test_burst_not_split();
        logic [AW-1:0] adr;
        apply_reset();
        adr = 32'h0000_0100;
        drive_master(0, 1'b1, 1'b1, 1'b0, adr, 32'h0, CTI_INC, BTE_BEAT4);
        tick();
        // m1 asks for the bus mid-burst.
        drive_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_0900, 32'h0, CTI_CLASSIC, BTE_LINEAR);
        for (int b = 0; b < 4; b++) begin
            s_ack_i = 1'b1;
            s_dat_i = 32'hA000_0000 + 32'(b);
            #1;
            if (m_ack_o !== 3'b001 || gnt_o !== 3'b001) begin
                $display("FAIL t2_beat%0d_ack: got ack=%b gnt=%b want ack=001 gnt=001", b, m_ack_o, gnt_o); errors++;
            end
            checks++;
            if (s_adr_o !== adr || s_cti_o !== m_cti[2:0] || s_bte_o !== BTE_BEAT4) begin
                $display("FAIL t2_beat%0d_fields: got adr=%h cti=%b bte=%b want adr=%h", b, s_adr_o, s_cti_o, s_bte_o, adr); errors++;
            end
            checks++;
            if (m_dat_o !== 32'hA000_0000 + 32'(b)) begin
                $display("FAIL t2_beat%0d_rdata: got %h want %h", b, m_dat_o, 32'hA000_0000 + 32'(b)); errors++;
            end
            checks++;
            tick();
            adr = adr + 32'd4;
            drive_master(0, 1'b1, 1'b1, 1'b0, adr, 32'h0, (b == 2) ? CTI_EOB : CTI_INC, BTE_BEAT4);
        end
        s_ack_i = 1'b0;
        drive_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC, BTE_LINEAR);
        tick();
        if (gnt_o !== 3'b000) begin
            $display("FAIL t2_bubble: got %b want 000", gnt_o); errors++;
        end
        checks++;
        tick();
        if (gnt_o !== 3'b010 || s_adr_o !== 32'h0000_0900) begin
            $display("FAIL t2_m1_gnt: got gnt=%b adr=%h want gnt=010 adr=00000900", gnt_o, s_adr_o); errors++;
        end
        checks++;
    endtask

    task automatic test_isolation();
        int ack1_seen;
        ack1_seen = 0;
        apply_reset();
        drive_master(0, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h1111_2222, CTI_CLASSIC, BTE_LINEAR);
        drive_master(1, 1'b1, 1'b1, 1'b0, 32'hDEAD_0000, 32'h5555_6666, CTI_INC, BTE_BEAT16);
        m_sel[SW +: SW] = 4'b0011;
        for (int c = 0; c < 6; c++) begin
            tick();
            s_ack_i = (c % 2 == 1);
            #1;
            if (m_ack_o[1] !== 1'b0) ack1_seen++;
            if (s_adr_o !== 32'h0000_0200 || s_we_o !== 1'b1 || s_dat_o !== 32'h1111_2222 || s_sel_o !== 4'hF) begin
                $display("FAIL t3_fields_c%0d: got adr=%h we=%b dat=%h sel=%h want adr=00000200 we=1 dat=11112222 sel=f",
                         c, s_adr_o, s_we_o, s_dat_o, s_sel_o); errors++;
            end
            checks++;
        end
        if (ack1_seen !== 0) begin
            $display("FAIL t3_no_ack_m1: got %0d cycles with ack[1] want 0", ack1_seen); errors++;
        end
        checks++;
        s_ack_i = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [NM-1:0] exp_gnt;
        apply_reset();
        for (int k = 0; k < NM; k++)
            drive_master(k, 1'b1, 1'b1, 1'b0, 32'(k) << 8, 32'h0, CTI_CLASSIC, BTE_LINEAR);
        for (int t = 0; t < 6; t++) begin
            exp_gnt = NM'(1) << (t % NM);
            tick();
            if (gnt_o !== exp_gnt) begin
                $display("FAIL t4_order_%0d: got %b want %b", t, gnt_o, exp_gnt); errors++;
            end
            checks++;
            s_ack_i = 1'b1;
            tick();
            s_ack_i = 1'b0;
            m_cyc[t % NM] = 1'b0;
            m_stb[t % NM] = 1'b0;
            tick();
            m_cyc[t % NM] = 1'b1;
            m_stb[t % NM] = 1'b1;
        end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        drive_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, CTI_INC, BTE_BEAT8);
        tick();
        drive_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, CTI_CLASSIC, BTE_LINEAR);
        #1;
        if (gnt_o !== 3'b010 || s_stb_o !== 1'b1) begin
            $display("FAIL t5_busy: got gnt=%b stb=%b want gnt=010 stb=1", gnt_o, s_stb_o); errors++;
        end
        checks++;
        #1;
        reset = 1'b1;
        #1;
        if ({s_cyc_o, s_stb_o} !== 2'b00 || gnt_o !== 3'b000) begin
            $display("FAIL t5_async_clear: got cyc=%b stb=%b gnt=%b want 0 0 000", s_cyc_o, s_stb_o, gnt_o); errors++;
        end
        checks++;
        tick();
        reset = 1'b0;
        tick();
        if (gnt_o !== 3'b001) begin
            $display("FAIL t5_next_gnt: got %b want 001", gnt_o); errors++;
        end
        checks++;
    endtask

    task automatic test_timeout();
        int err_cycles;
        int err_at;
        int stb_low;
        logic stb_at_err;
        err_cycles = 0;
        err_at     = -1;
        stb_low    = 0;
        stb_at_err = 1'b1;
        apply_reset();
        drive_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, CTI_CLASSIC, BTE_LINEAR);
        tick();
        // j counts edges after the grant edge; stb has been high j cycles.
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (m_err_o !== 3'b000) begin
                err_cycles++;
                err_at = j;
                stb_at_err = s_stb_o;
                if (m_err_o !== 3'b001) begin
                    $display("FAIL t6_err_target: got %b want 001", m_err_o); errors++;
                end
                checks++;
            end
            if (s_stb_o !== 1'b1) stb_low++;
        end
`ifdef WB_ARB_TIMEOUT_EN
        if (err_cycles !== 1 || err_at !== 8) begin
            $display("FAIL t6_err_pulse: got %0d pulses at cycle %0d want 1 pulse at cycle 8", err_cycles, err_at); errors++;
        end
        checks++;
        if (stb_at_err !== 1'b0 || stb_low !== 1) begin
            $display("FAIL t6_stb_mask: got stb=%b low_cycles=%0d want stb=0 low_cycles=1", stb_at_err, stb_low); errors++;
        end
        checks++;
`else
        if (err_cycles !== 0) begin
            $display("FAIL t6_no_err: got %0d pulses want 0", err_cycles); errors++;
        end
        checks++;
        if (stb_low !== 0 || gnt_o !== 3'b001) begin
            $display("FAIL t6_hung_hold: got low_cycles=%0d gnt=%b want 0 and 001", stb_low, gnt_o); errors++;
        end
        checks++;
`endif
        drive_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC, BTE_LINEAR);
        tick();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_first_grant();
        test_burst_not_split();
        test_isolation();
        test_round_robin();
        test_reset_mid_burst();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
